// File: rtl/program_executor_if.sv
// Memory bus between the program executor (master) and its program/data memory (slave).
interface program_executor_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/program_executor.sv
// Multi-cycle accumulator-style program executor: fetch / execute over a single
// read-latency-1 memory port, with illegal-opcode and step-timeout faults.
module program_executor #(
  parameter int unsigned MAX_STEPS = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  program_executor_if.master mem,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic               div_by_zero,
  output logic [15:0]        result,
  output logic [7:0]         pc
);
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 16;
  localparam int unsigned OW = 4;

  localparam logic [OW-1:0] OP_BRA = 4'd0;
  localparam logic [OW-1:0] OP_LDA = 4'd1;
  localparam logic [OW-1:0] OP_LDB = 4'd2;
  localparam logic [OW-1:0] OP_STR = 4'd3;
  localparam logic [OW-1:0] OP_ADD = 4'd4;
  localparam logic [OW-1:0] OP_SUB = 4'd5;
  localparam logic [OW-1:0] OP_MUL = 4'd6;
  localparam logic [OW-1:0] OP_DIV = 4'd7;
  localparam logic [OW-1:0] OP_HLT = 4'd8;
  localparam logic [OW-1:0] OP_OR  = 4'd9;
  localparam logic [OW-1:0] OP_AND = 4'd10;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_EXECUTE,
    S_LOAD_WAIT,
    S_HALTED,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] c_q, c_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [SW-1:0] step_q, step_d;
  logic          dbz_q, dbz_d;
  logic [1:0]    fcode_q, fcode_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic [OW-1:0] ir_op;
  logic [AW-1:0] ir_addr;
  logic [OW-1:0] fetch_op;
  logic [OW-1:0] next_op;
  logic          ir_is_alu;
  logic [DW-1:0] alu_c;
  logic          alu_dbz;
  logic          unused_ir_bits;

  assign ir_op          = ir_q[15:12];
  assign ir_addr        = ir_q[7:0];
  assign fetch_op       = mem.mem_rdata[15:12];
  assign unused_ir_bits = ^ir_q[11:8];

  // ALU result for the instruction held in IR
  always_comb begin
    alu_c     = c_q;
    alu_dbz   = 1'b0;
    ir_is_alu = 1'b1;
    case (ir_op)
      OP_ADD: alu_c = a_q + b_q;
      OP_SUB: alu_c = a_q - b_q;
      OP_MUL: alu_c = a_q * b_q;
      OP_DIV: begin
        if (b_q == '0) begin
          alu_c   = '1;
          alu_dbz = 1'b1;
        end else begin
          alu_c = a_q / b_q;
        end
      end
      OP_OR:   alu_c = a_q | b_q;
      OP_AND:  alu_c = a_q & b_q;
      default: ir_is_alu = 1'b0;
    endcase
  end

  // Next-state, datapath updates and registered bus/status outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    ir_d       = ir_q;
    step_d     = step_q;
    dbz_d      = dbz_q;
    fcode_d    = fcode_q;
    mem_addr_d = '0;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    next_op    = '0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          a_d     = '0;
          b_d     = '0;
          c_d     = '0;
          step_d  = '0;
          dbz_d   = 1'b0;
          fcode_d = FC_NONE;
        end
      end
      S_FETCH: state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        ir_d   = mem.mem_rdata;
        step_d = step_q + SW'(1);
        if ((step_d == SW'(MAX_STEPS)) && (fetch_op != OP_HLT)) begin
          state_d = S_FAULT;
          fcode_d = FC_TIMEOUT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (ir_is_alu) begin
          c_d     = alu_c;
          dbz_d   = dbz_q | alu_dbz;
          pc_d    = pc_q + AW'(1);
          state_d = S_FETCH;
        end else begin
          case (ir_op)
            OP_LDA, OP_LDB: state_d = S_LOAD_WAIT;
            OP_STR: begin
              pc_d    = pc_q + AW'(1);
              state_d = S_FETCH;
            end
            OP_BRA: begin
              pc_d    = ir_addr;
              state_d = S_FETCH;
            end
            OP_HLT: state_d = S_HALTED;
            default: begin
              state_d = S_FAULT;
              fcode_d = FC_ILLEGAL;
            end
          endcase
        end
      end
      S_LOAD_WAIT: begin
        if (ir_op == OP_LDA) begin
          a_d = mem.mem_rdata;
        end else begin
          b_d = mem.mem_rdata;
        end
        pc_d    = pc_q + AW'(1);
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Bus strobes and status are registered against the state being entered
    busy_d  = !(state_d inside {S_IDLE, S_HALTED, S_FAULT});
    done_d  = (state_d == S_HALTED);
    fault_d = (state_d == S_FAULT);
    next_op = ir_d[15:12];
    if (state_d == S_FETCH) begin
      mem_addr_d = pc_d;
      mem_rd_d   = 1'b1;
    end else if (state_d == S_EXECUTE) begin
      if ((next_op == OP_LDA) || (next_op == OP_LDB)) begin
        mem_addr_d = ir_d[7:0];
        mem_rd_d   = 1'b1;
      end else if (next_op == OP_STR) begin
        mem_addr_d = ir_d[7:0];
        mem_wr_d   = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      ir_q       <= '0;
      step_q     <= '0;
      dbz_q      <= 1'b0;
      fcode_q    <= FC_NONE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      ir_q       <= ir_d;
      step_q     <= step_d;
      dbz_q      <= dbz_d;
      fcode_q    <= fcode_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_rd    = mem_rd_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_wdata = c_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign fault_code    = fcode_q;
  assign div_by_zero   = dbz_q;
  assign result        = c_q;
  assign pc            = pc_q;
endmodule

// File: tb/tb_program_executor.sv
// Bench for program_executor: directed programs plus random programs, checked
// against an instruction-level interpreter of the same machine.
module tb_program_executor;
  localparam int MAX_STEPS = 64;
  localparam int BUDGET    = 1000;

  localparam logic [3:0] I_BRA = 4'd0;
  localparam logic [3:0] I_LDA = 4'd1;
  localparam logic [3:0] I_LDB = 4'd2;
  localparam logic [3:0] I_STR = 4'd3;
  localparam logic [3:0] I_ADD = 4'd4;
  localparam logic [3:0] I_SUB = 4'd5;
  localparam logic [3:0] I_MUL = 4'd6;
  localparam logic [3:0] I_DIV = 4'd7;
  localparam logic [3:0] I_HLT = 4'd8;
  localparam logic [3:0] I_OR  = 4'd9;
  localparam logic [3:0] I_AND = 4'd10;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, fault, div_by_zero;
  logic [1:0]  fault_code;
  logic [15:0] result;
  logic [7:0]  pc;

  program_executor_if mif();

  program_executor #(.MAX_STEPS(MAX_STEPS)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mem         (mif),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .fault_code  (fault_code),
    .div_by_zero (div_by_zero),
    .result      (result),
    .pc          (pc)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [256];
  int          wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          rd_count = 0;
  bit          overlap  = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  // Memory model: one-cycle read latency, writes logged in order
  always @(posedge clock) begin
    if (mif.mem_rd === 1'b1) begin
      mif.mem_rdata <= mem[mif.mem_addr];
      rd_count = rd_count + 1;
    end
    if (mif.mem_wr === 1'b1) begin
      mem[mif.mem_addr] = mif.mem_wdata;
      wr_addr_q.push_back(int'(mif.mem_addr));
      wr_data_q.push_back(mif.mem_wdata);
    end
    if ((mif.mem_rd === 1'b1) && (mif.mem_wr === 1'b1)) overlap = 1'b1;
  end

  // Interpreter results
  int          m_cycles;
  logic [15:0] m_c;
  logic [7:0]  m_pc;
  logic [1:0]  m_fc;
  logic        m_dbz;
  int          m_wa[$];
  logic [15:0] m_wd[$];

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] opd);
    return {op, opd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Executes the current memory image instruction by instruction
  task automatic model_run();
    logic [15:0] mm [256];
    logic [15:0] a, b, c, w;
    logic [7:0]  p, opd;
    logic [3:0]  op;
    logic [31:0] prod;
    int          steps;
    bit          stop;
    mm = mem;
    a = 0; b = 0; c = 0; p = 0; steps = 0; stop = 1'b0;
    m_cycles = 0; m_fc = 2'd0; m_dbz = 1'b0;
    m_wa.delete(); m_wd.delete();
    while (!stop) begin
      w = mm[p]; op = w[15:12]; opd = w[7:0];
      steps++;
      if (steps == MAX_STEPS && op != I_HLT) begin
        m_fc = 2'd2; m_cycles += 2; stop = 1'b1;
      end else begin
        m_cycles += (op == I_LDA || op == I_LDB) ? 4 : 3;
        case (op)
          I_BRA: p = opd;
          I_LDA: begin a = mm[opd]; p++; end
          I_LDB: begin b = mm[opd]; p++; end
          I_STR: begin mm[opd] = c; m_wa.push_back(int'(opd)); m_wd.push_back(c); p++; end
          I_ADD: begin c = a + b; p++; end
          I_SUB: begin c = a - b; p++; end
          I_MUL: begin prod = 32'(a) * 32'(b); c = prod[15:0]; p++; end
          I_DIV: begin
            if (b == 0) begin c = 16'hFFFF; m_dbz = 1'b1; end
            else c = a / b;
            p++;
          end
          I_HLT: stop = 1'b1;
          I_OR:  begin c = a | b; p++; end
          I_AND: begin c = a & b; p++; end
          default: begin m_fc = 2'd1; stop = 1'b1; end
        endcase
      end
    end
    m_c = c; m_pc = p;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(done === 1'b1 || fault === 1'b1) && n < BUDGET) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic check_all_zero(input string name);
    check($sformatf("%s.busy", name),     32'(busy), 32'(0));
    check($sformatf("%s.done", name),     32'(done), 32'(0));
    check($sformatf("%s.fault", name),    32'(fault), 32'(0));
    check($sformatf("%s.fcode", name),    32'(fault_code), 32'(0));
    check($sformatf("%s.dbz", name),      32'(div_by_zero), 32'(0));
    check($sformatf("%s.result", name),   32'(result), 32'(0));
    check($sformatf("%s.pc", name),       32'(pc), 32'(0));
    check($sformatf("%s.mem_rd", name),   32'(mif.mem_rd), 32'(0));
    check($sformatf("%s.mem_wr", name),   32'(mif.mem_wr), 32'(0));
    check($sformatf("%s.mem_addr", name), 32'(mif.mem_addr), 32'(0));
  endtask

  // Start the loaded program and compare every observable against the interpreter
  task automatic run_and_check(input string name);
    int n, wbase, nw;
    model_run();
    wbase = wr_addr_q.size();
    pulse_start();
    check($sformatf("%s.first_rd", name),   32'(mif.mem_rd), 32'(1));
    check($sformatf("%s.first_addr", name), 32'(mif.mem_addr), 32'(0));
    wait_end(n);
    check($sformatf("%s.cycles", name), 32'(n), 32'(m_cycles));
    check($sformatf("%s.done", name),   32'(done), 32'(m_fc == 2'd0));
    check($sformatf("%s.fault", name),  32'(fault), 32'(m_fc != 2'd0));
    check($sformatf("%s.fcode", name),  32'(fault_code), 32'(m_fc));
    check($sformatf("%s.busy", name),   32'(busy), 32'(0));
    check($sformatf("%s.result", name), 32'(result), 32'(m_c));
    check($sformatf("%s.pc", name),     32'(pc), 32'(m_pc));
    check($sformatf("%s.dbz", name),    32'(div_by_zero), 32'(m_dbz));
    nw = wr_addr_q.size() - wbase;
    check($sformatf("%s.nwrites", name), 32'(nw), 32'(m_wa.size()));
    for (int i = 0; i < m_wa.size(); i++) begin
      if (i < nw) begin
        check($sformatf("%s.waddr%0d", name, i), 32'(wr_addr_q[wbase+i]), 32'(m_wa[i]));
        check($sformatf("%s.wdata%0d", name, i), 32'(wr_data_q[wbase+i]), 32'(m_wd[i]));
      end
    end
  endtask

  task automatic load_arith(input logic [3:0] alu_op, input logic [15:0] va, input logic [15:0] vb);
    clear_mem();
    mem[0]  = ins(I_LDA, 12'd9);
    mem[1]  = ins(I_LDB, 12'd10);
    mem[2]  = ins(alu_op, 12'd0);
    mem[3]  = ins(I_STR, 12'd15);
    mem[4]  = ins(I_HLT, 12'd0);
    mem[9]  = va;
    mem[10] = vb;
  endtask

  initial begin
    int n, wbase, rbase, len, seen;
    logic [3:0] op;
    int op_pool[12] = '{1, 1, 2, 2, 3, 4, 5, 6, 7, 9, 10, 0};

    clear_mem();
    start = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset_with_start");
    start = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    check_all_zero("idle");

    // Basic program: 7 + 5 stored to mem[15]
    load_arith(I_ADD, 16'd7, 16'd5);
    wbase = wr_addr_q.size();
    run_and_check("add");
    check("add.cycles_17", 32'(m_cycles), 32'(17));
    check("add.result_12", 32'(result), 32'(12));
    check("add.pc_4",      32'(pc), 32'(4));
    check("add.wr15",      32'(mem[15]), 32'(12));
    check("add.onewrite",  32'(wr_addr_q.size() - wbase), 32'(1));

    load_arith(I_SUB, 16'd5, 16'd7);
    run_and_check("sub");
    check("sub.result", 32'(result), 32'(16'hFFFE));

    load_arith(I_MUL, 16'd300, 16'd300);
    run_and_check("mul");
    check("mul.result", 32'(result), 32'(24464));

    load_arith(I_DIV, 16'd100, 16'd0);
    run_and_check("div0");
    check("div0.result", 32'(result), 32'(16'hFFFF));
    check("div0.dbz",    32'(div_by_zero), 32'(1));
    pulse_start();
    check("div0.restart_dbz_clr", 32'(div_by_zero), 32'(0));
    check("div0.restart_busy",    32'(busy), 32'(1));
    wait_end(n);
    check("div0.rerun_done", 32'(done), 32'(1));
    check("div0.rerun_dbz",  32'(div_by_zero), 32'(1));

    load_arith(I_DIV, 16'd100, 16'd7);
    run_and_check("div");
    check("div.result", 32'(result), 32'(14));

    // Illegal opcode: fault, no writes, start ignored, reset recovers
    clear_mem();
    mem[0] = 16'hB000;
    wbase = wr_addr_q.size();
    run_and_check("illegal");
    rbase = rd_count;
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    start = 1'b0;
    check("illegal.stuck_fault", 32'(fault), 32'(1));
    check("illegal.stuck_code",  32'(fault_code), 32'(1));
    check("illegal.stuck_busy",  32'(busy), 32'(0));
    check("illegal.no_reads",    32'(rd_count - rbase), 32'(0));
    check("illegal.no_writes",   32'(wr_addr_q.size() - wbase), 32'(0));
    do_reset();
    check_all_zero("illegal_reset");

    // Endless branch: step timeout after exactly 64 fetches
    clear_mem();
    mem[0] = ins(I_BRA, 12'd0);
    rbase = rd_count;
    run_and_check("timeout");
    check("timeout.code",    32'(fault_code), 32'(2));
    check("timeout.fetches", 32'(rd_count - rbase), 32'(64));
    do_reset();

    // Reset during the store cycle
    load_arith(I_ADD, 16'd7, 16'd5);
    pulse_start();
    seen = 0;
    n = 0;
    while (seen == 0 && n < BUDGET) begin
      if (mif.mem_wr === 1'b1) seen = 1;
      else begin @(posedge clock); #1; n++; end
    end
    check("rst_str.saw_wr", 32'(seen), 32'(1));
    wbase = wr_addr_q.size();
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_zero("rst_str");
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("rst_str.nwrites", 32'(wr_addr_q.size() - wbase), 32'(1));
    check("rst_str.idle_wr", 32'(mif.mem_wr), 32'(0));
    run_and_check("after_reset");

    // pc wraps past 8'hFF into an instruction written by the program itself
    clear_mem();
    mem[0]   = ins(I_BRA, 12'd252);
    mem[252] = ins(I_LDA, 12'd200);
    mem[253] = ins(I_ADD, 12'd0);
    mem[254] = ins(I_STR, 12'd0);
    mem[255] = ins(I_ADD, 12'd0);
    mem[200] = 16'h8000;
    run_and_check("wrap");
    check("wrap.pc",     32'(pc), 32'(0));
    check("wrap.done",   32'(done), 32'(1));
    check("wrap.cycles", 32'(m_cycles), 32'(19));

    // Random programs
    for (int t = 0; t < 30; t++) begin
      clear_mem();
      for (int i = 128; i < 256; i++) begin
        case ($urandom_range(0, 3))
          0:       mem[i] = 16'h0000;
          1:       mem[i] = 16'($urandom_range(0, 15));
          default: mem[i] = 16'($urandom);
        endcase
      end
      len = int'($urandom_range(3, 20));
      for (int i = 0; i < len - 1; i++) begin
        if ($urandom_range(0, 39) == 0) op = 4'($urandom_range(11, 15));
        else op = 4'(op_pool[$urandom_range(0, 11)]);
        case (op)
          I_LDA, I_LDB: mem[i] = ins(op, {4'($urandom), 8'($urandom_range(128, 255))});
          I_STR:        mem[i] = ins(op, {4'($urandom), 8'($urandom_range(64, 127))});
          I_BRA:        mem[i] = ins(op, {4'($urandom), 8'($urandom_range(0, len - 1))});
          default:      mem[i] = ins(op, 12'($urandom));
        endcase
      end
      mem[len-1] = ins(I_HLT, 12'($urandom));
      run_and_check($sformatf("rand%0d", t));
      if (fault === 1'b1) do_reset();
    end

    check("rd_wr_overlap", 32'(overlap), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_executor.md
PROGRAM_EXECUTOR -- requirements
Module: program_executor

Interface
REQ-001 Parameter: MAX_STEPS, 64, number of instructions executed without HLT before a timeout fault (range 1..65535).
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level; sampled only in IDLE and HALTED.
REQ-005 mem_addr  output  8  memory address for fetch, load and store.
REQ-006 mem_rd  output  1  read strobe; mem_rdata is valid the cycle after mem_rd=1.
REQ-007 mem_rdata  input  16  memory read data.
REQ-008 mem_wr  output  1  single-cycle write strobe.
REQ-009 mem_wdata  output  16  write data (register C).
REQ-010 busy  output  1  high in every state except IDLE, HALTED and FAULT.
REQ-011 done  output  1  high while in HALTED.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 fault_code  output  2  0 none, 1 illegal opcode, 2 step timeout.
REQ-014 div_by_zero  output  1  sticky; set by DIV with B=0.
REQ-015 result  output  16  current register C.
REQ-016 pc  output  8  current program counter.

Function
REQ-017 Instruction word: [15:12] opcode, [11:0] operand; only operand[7:0] is used as an address.
REQ-018 Opcodes: 0 BRA, 1 LD_A, 2 LD_B, 3 STR, 4 ADD, 5 SUB, 6 MUL, 7 DIV, 8 HLT, 9 OR, 10 AND; 11-15 illegal.
REQ-019 States: IDLE, FETCH, FETCH_WAIT, EXECUTE, LOAD_WAIT, HALTED, FAULT; each state lasts exactly one cycle except IDLE, HALTED and FAULT.
REQ-020 IDLE/HALTED with start=1 -> FETCH; pc, A, B, C, step count, div_by_zero and fault_code all cleared on the same edge.
REQ-021 FETCH: mem_addr=pc, mem_rd=1 -> FETCH_WAIT.
REQ-022 FETCH_WAIT: IR <= mem_rdata, step count +1 -> EXECUTE.
REQ-023 EXECUTE, ALU ops (4-7, 9, 10): C <= f(A,B); pc+1 -> FETCH.
REQ-024 EXECUTE, LD_A/LD_B: mem_addr=operand, mem_rd=1 -> LOAD_WAIT; LOAD_WAIT: A or B <= mem_rdata, pc+1 -> FETCH.
REQ-025 EXECUTE, STR: mem_addr=operand, mem_wdata=C, mem_wr=1 for this cycle only; pc+1 -> FETCH.
REQ-026 EXECUTE, BRA: pc <= operand[7:0] -> FETCH.
REQ-027 EXECUTE, HLT: -> HALTED; pc unchanged.
REQ-028 EXECUTE, illegal opcode: -> FAULT, fault_code=1; no memory access.
REQ-029 Step count reaches MAX_STEPS in FETCH_WAIT and IR is not HLT: -> FAULT, fault_code=2 (that instruction is not executed).
REQ-030 Cycles per instruction: ALU, STR, BRA and HLT take 3; LD_A/LD_B take 4.
REQ-031 Arithmetic is unsigned 16-bit: ADD and SUB wrap modulo 2^16; MUL keeps the low 16 bits of the product; DIV gives the quotient floor(A/B).
REQ-032 DIV with B=0: C <= 16'hFFFF, div_by_zero <= 1.
REQ-033 AND and OR are bitwise on A and B.
REQ-034 pc increments wrap 8'hFF -> 8'h00 with no fault.
REQ-035 start is ignored while busy=1 or in FAULT; only reset leaves FAULT.
REQ-036 mem_rd and mem_wr are never high in the same cycle; both are 0 outside the states above.

Reset
REQ-037 reset=1 at any edge: state IDLE; pc, A, B, C, IR and step count = 0; all outputs 0; overrides start.
REQ-038 Reset during EXECUTE of STR: mem_wr=0 from the next cycle, and no further write occurs.

Verification
REQ-039 mem[0..4]={LD_A 9, LD_B 10, ADD, STR 15, HLT}, mem[9]=7, mem[10]=5, pulse start -> exactly one write mem[15]=12; done rises 17 clocks after start is sampled; result=12; pc=4.
REQ-040 Same program with SUB, mem[9]=5, mem[10]=7 -> write 16'hFFFE; with MUL, mem[9]=mem[10]=300 -> write 24464.
REQ-041 DIV with mem[10]=0 -> write 16'hFFFF, div_by_zero=1, done=1; restart with start -> div_by_zero cleared.
REQ-042 mem[0]=16'hB000 -> fault=1, fault_code=1, mem_wr never asserted, busy=0; start ignored; reset -> IDLE.
REQ-043 mem[0]=BRA 0, MAX_STEPS=64 -> fault_code=2 after exactly 64 fetches; no writes.
REQ-044 Assert reset in the STR EXECUTE cycle -> mem_wr low after the edge; all outputs 0; a new start runs the program from pc=0.
